// File: rtl/lcd_pkg.sv
// Shared constants, default timing and FSM state type for the LCD write scheduler.
package lcd_pkg;

  localparam int unsigned LCD_COLS    = 16;
  localparam int unsigned LCD_TEXT_W  = 128;
  localparam int unsigned LCD_MAX_LEN = 16;
  localparam int unsigned LCD_LEN_W   = 8;
  localparam int unsigned LCD_CNT_W   = 24;

  // 22 ms power-up blackout and per-slot hold at 50 MHz
  localparam int unsigned INIT_CYCLES_DEF = 1_100_000;
  localparam int unsigned SLOT_CYCLES_DEF = 2_100;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StHold
  } lcd_state_e;

  function automatic logic [LCD_LEN_W-1:0] clamp_len(input logic [LCD_LEN_W-1:0] len);
    return (len > LCD_LEN_W'(LCD_MAX_LEN)) ? LCD_LEN_W'(LCD_MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/lcd_req_arbiter.sv
// Requester winner select: round-robin with last-winner pointer, or fixed priority
// (lowest index wins, no state) when LCD_SCHED_FIXED_PRIO_EN is defined.
module lcd_req_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IdxW    = 2
) (
`ifndef LCD_SCHED_FIXED_PRIO_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance_i,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    winner_o
);

`ifdef LCD_SCHED_FIXED_PRIO_EN

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o  = 1'b1;
        winner_o = IdxW'(i);
      end
    end
  end

`else

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Search begins one past the last winner; the last winner itself has lowest priority.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(ptr_q) + off) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o  = 1'b1;
        winner_o = cand_idx;
      end
    end
  end

  assign ptr_d = advance_i ? winner_o : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates text writes from several requesters onto one slow character LCD controller,
// blanking during power-up init and holding per command slot. Macro: LCD_SCHED_FIXED_PRIO_EN.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ*5-1:0]    req_x_i,
  input  logic [NUM_REQ*2-1:0]    req_y_i,
  input  logic [NUM_REQ*128-1:0]  req_text_i,
  input  logic [NUM_REQ*8-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic                    lcd_write_req_o,
  output logic [4:0]              lcd_x_pos_o,
  output logic [1:0]              lcd_y_pos_o,
  output logic [LCD_TEXT_W-1:0]   lcd_text_o,
  output logic [LCD_LEN_W-1:0]    lcd_text_len_o,
  output logic                    busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = LCD_CNT_W;
  localparam logic [CntW-1:0] InitLast = CntW'(INIT_CYCLES - 1);

  lcd_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [4:0]              x_q, x_d;
  logic [1:0]              y_q, y_d;
  logic [LCD_TEXT_W-1:0]   text_q, text_d;
  logic [LCD_LEN_W-1:0]    len_q, len_d;

  logic                    win_valid;
  logic [IdxW-1:0]         win_idx;
  logic [LCD_LEN_W-1:0]    win_len;
  logic [CntW-1:0]         hold_cycles;

`ifndef LCD_SCHED_FIXED_PRIO_EN
  logic advance;
  assign advance = (state_q == StIdle) && win_valid;
`endif

  lcd_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_arbiter (
`ifndef LCD_SCHED_FIXED_PRIO_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (advance),
`endif
    .req_i     (req_i),
    .valid_o   (win_valid),
    .winner_o  (win_idx)
  );

  assign win_len     = clamp_len(req_len_i[32'(win_idx)*8 +: 8]);
  // One address-set slot plus one slot per character
  assign hold_cycles = CntW'((32'(win_len) + 32'd1) * SLOT_CYCLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    wr_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    text_d  = text_q;
    len_d   = len_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q >= InitLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (win_valid) begin
          gnt_d[win_idx] = 1'b1;
          // Zero-length grants only consume the request; outputs keep their last values
          if (win_len != '0) begin
            wr_d    = 1'b1;
            x_d     = req_x_i[32'(win_idx)*5 +: 5];
            y_d     = req_y_i[32'(win_idx)*2 +: 2];
            text_d  = req_text_i[32'(win_idx)*128 +: 128];
            len_d   = win_len;
            state_d = StHold;
            cnt_d   = hold_cycles;
          end
        end
      end
      StHold: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      text_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      text_q  <= text_d;
      len_q   <= len_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign lcd_write_req_o = wr_q;
  assign lcd_x_pos_o     = x_q;
  assign lcd_y_pos_o     = y_q;
  assign lcd_text_o      = text_q;
  assign lcd_text_len_o  = len_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomized scoreboard bench for lcd_write_scheduler against a time-slot reference model.
module tb_lcd_write_scheduler;

  localparam int unsigned N    = 3;
  localparam int unsigned INIT = 10;
  localparam int unsigned SLOT = 4;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req      = '0;
  logic [N*5-1:0]       req_x    = '0;
  logic [N*2-1:0]       req_y    = '0;
  logic [N*128-1:0]     req_text = '0;
  logic [N*8-1:0]       req_len  = '0;
  logic [N-1:0]         gnt;
  logic                 lcd_wr;
  logic [4:0]           lcd_x;
  logic [1:0]           lcd_y;
  logic [127:0]         lcd_text;
  logic [7:0]           lcd_len;
  logic                 busy;

  lcd_write_scheduler #(
    .NUM_REQ     (N),
    .INIT_CYCLES (INIT),
    .SLOT_CYCLES (SLOT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .req_x_i         (req_x),
    .req_y_i         (req_y),
    .req_text_i      (req_text),
    .req_len_i       (req_len),
    .gnt_o           (gnt),
    .lcd_write_req_o (lcd_wr),
    .lcd_x_pos_o     (lcd_x),
    .lcd_y_pos_o     (lcd_y),
    .lcd_text_o      (lcd_text),
    .lcd_text_len_o  (lcd_len),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  edge_n;
    logic [N-1:0] gnt;
    logic         wr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: earliest edge a grant may happen, last winner, output mirror
  int unsigned  next_ok = 0;
  int           last_w  = 0;
  bit           in_rst  = 1'b1;
  int           rel_w   = -1;
  logic [4:0]   m_x     = '0;
  logic [1:0]   m_y     = '0;
  logic [127:0] m_text  = '0;
  logic [7:0]   m_len   = '0;
  int unsigned  idle[N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic new_req(input int i);
    int unsigned r;
    logic [7:0]  l;
    r = $urandom_range(0, 9);
    if (r == 0)      l = 8'd0;
    else if (r == 1) l = 8'($urandom_range(17, 255));
    else             l = 8'($urandom_range(1, 16));
    req_x[i*5 +: 5]      = 5'($urandom_range(0, 31));
    req_y[i*2 +: 2]      = 2'($urandom_range(0, 3));
    req_text[i*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_len[i*8 +: 8]    = l;
    req[i]               = 1'b1;
  endtask

  // Decide whether the coming edge grants, from the current request levels.
  task automatic model_step();
    int unsigned  e;
    int           w;
    logic [7:0]   cl;
    logic [N-1:0] one;
    exp_t         item;
    e   = cyc + 1;
    w   = -1;
    one = 1;
    if (in_rst || e < next_ok || req == '0) return;
`ifdef LCD_SCHED_FIXED_PRIO_EN
    for (int k = N - 1; k >= 0; k--) if (req[k]) w = k;
`else
    for (int k = N; k >= 1; k--) if (req[(last_w + k) % N]) w = (last_w + k) % N;
`endif
    cl = (req_len[w*8 +: 8] > 8'd16) ? 8'd16 : req_len[w*8 +: 8];
    item.edge_n = e;
    item.gnt    = one << w;
    item.wr     = (cl != 0);
    exp_q.push_back(item);
    if (cl != 0) begin
      m_x     = req_x[w*5 +: 5];
      m_y     = req_y[w*2 +: 2];
      m_text  = req_text[w*128 +: 128];
      m_len   = cl;
      next_ok = e + (32'(cl) + 1) * SLOT + 1;
    end else begin
      next_ok = e + 1;
    end
    last_w = w;
    rel_w  = w;
  endtask

  task automatic step(input int unsigned maxidle);
    @(negedge clk);
    if (rel_w >= 0) begin
      req[rel_w]  = 1'b0;
      idle[rel_w] = $urandom_range(0, maxidle);
      rel_w       = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i]) begin
        if (idle[i] == 0) new_req(i);
        else idle[i]--;
      end
    end
    model_step();
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    in_rst  = 1'b0;
    next_ok = cyc + INIT + 1;
    last_w  = 0;
  endtask

  logic [N-1:0] mon_gnt;
  logic         mon_wr;

  always @(posedge clk) begin
    #1;
    mon_gnt = '0;
    mon_wr  = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
      chk("grant_edge", 128'(cyc), 128'(exp_q[0].edge_n));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
      mon_gnt = exp_q[0].gnt;
      mon_wr  = exp_q[0].wr;
      void'(exp_q.pop_front());
    end
    chk("gnt", gnt, mon_gnt);
    chk("lcd_write_req", lcd_wr, mon_wr);
    chk("busy", busy, in_rst || (cyc + 1 < next_ok));
    chk("lcd_x_pos", lcd_x, m_x);
    chk("lcd_y_pos", lcd_y, m_y);
    chk("lcd_text", lcd_text, m_text);
    chk("lcd_text_len", lcd_len, m_len);
  end

  initial begin
    idle[0] = 0;
    idle[1] = 40;
    idle[2] = 40;
    // Requester 0 waits through the whole init blackout
    new_req(0);
    req_len[7:0] = 8'd5;
    repeat (3) @(negedge clk);
    release_reset();
    model_step();

    repeat (1500) step(20);
    repeat (600) step(0);

    // Reset in the middle of a hold (or init) window
    for (int k = 0; k < 300; k++) begin
      if (cyc + 3 < next_ok) break;
      step(0);
    end
    rst_n  = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    rel_w  = -1;
    m_x    = '0;
    m_y    = '0;
    m_text = '0;
    m_len  = '0;
    if (req == '0) new_req(2);
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_lcd_write_req", lcd_wr, 1'b0);
    chk("rst_lcd_text", lcd_text, '0);
    chk("rst_lcd_text_len", lcd_len, '0);
    chk("rst_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    release_reset();
    model_step();

    repeat (800) step(10);
    @(negedge clk);
    req = '0;
    rel_w = -1;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
